pulse_receiver_capture: RTL and testbench

Receive-side counterpart to the pulse transmitter. It samples an external pulse pin, measures the duration of each high/low segment in prescaled clock ticks, and queues {level, duration} records in a small first-word-fall-through FIFO. The TinyQV peripheral register block reads the records. The block also flags idle-line timeouts and FIFO overflow.

---
 rtl/pulse_receiver_capture.sv | 164 ++++++++++++++++
 tb/tb_pulse_receiver_capture.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_receiver_capture.sv
// pulse_receiver_capture
// Measures the high/low segments of an asynchronous pulse pin in prescaled
// ticks and queues {idle, level, duration} records in a small FWFT FIFO.
//
// Ports:
//   clk, sys_rst_n     clock, asynchronous active-low reset
//   en                 capture enable (counters/arming held clear when low)
//   invert             invert synchronized level before measurement
//   prescale           tick = prescale+1 clocks
//   idle_threshold     idle timeout in ticks, 0 disables
//   sig_in             asynchronous pulse pin
//   rd_en              pop FIFO head
//   rd_data            head record {idle, level, duration}, 0 when empty
//   rd_valid           FIFO not empty
//   fifo_count         occupancy 0..FIFO_DEPTH
//   overflow           sticky record-dropped flag
//   overflow_clr       clear overflow (an overflow in the same cycle wins)
//   idle_irq           one-cycle pulse, coincident with the idle record appearing
module pulse_receiver_capture #(
  parameter int CNT_WIDTH      = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic                          en,
  input  logic                          invert,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic [CNT_WIDTH-1:0]          idle_threshold,
  input  logic                          sig_in,
  input  logic                          rd_en,
  output logic [CNT_WIDTH+1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          idle_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                 idle;
    logic                 level;
    logic [CNT_WIDTH-1:0] dur;
  } rec_t;

  // input path
  logic [1:0] sync_pipe;
  logic       lvl, lvl_q, edge_det;

  // measurement
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic [CNT_WIDTH-1:0]      dur;
  logic                      armed, tick, idle_hit;

  // fifo
  rec_t [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  push, pop, full, wr_ok, drop;
  rec_t                  push_rec;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_pipe <= '0;
      lvl_q     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], sig_in};
      lvl_q     <= lvl;
    end
  end

  assign lvl      = sync_pipe[1] ^ invert;
  assign edge_det = lvl != lvl_q;
  // >= rather than == so a prescale reduced below the running count still wraps
  assign tick     = presc_cnt >= prescale;
  assign idle_hit = en && armed && (idle_threshold != '0) && !edge_det
                    && (dur == idle_threshold);

  always_comb begin
    push           = 1'b0;
    push_rec       = '0;
    if (en && edge_det && armed) begin
      push           = 1'b1;
      push_rec.level = lvl_q;
      push_rec.dur   = dur;
    end else if (idle_hit) begin
      push           = 1'b1;
      push_rec.idle  = 1'b1;
      push_rec.level = lvl_q;
      push_rec.dur   = dur;
    end
  end

  // The edge cycle is the first cycle of the new segment, so the reload
  // already accounts for it: a full tick when prescale is 0, else one clock.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_cnt <= '0;
      dur       <= '0;
      armed     <= 1'b0;
      idle_irq  <= 1'b0;
    end else begin
      idle_irq <= idle_hit;
      if (!en) begin
        presc_cnt <= '0;
        dur       <= '0;
        armed     <= 1'b0;
      end else if (edge_det) begin
        armed <= 1'b1;
        if (prescale == '0) begin
          dur       <= CNT_WIDTH'(1);
          presc_cnt <= '0;
        end else begin
          dur       <= '0;
          presc_cnt <= PRESCALE_WIDTH'(1);
        end
      end else begin
        if (tick) begin
          presc_cnt <= '0;
          if (!(&dur)) dur <= dur + CNT_WIDTH'(1);
        end else begin
          presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
        end
        if (idle_hit) armed <= 1'b0;
      end
    end
  end

  assign pop   = rd_en && (count != '0);
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign rd_valid   = count != '0;
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_pulse_receiver_capture.sv
// Directed bench for pulse_receiver_capture (default parameters).
// Record encoding: idle<<13 | level<<12 | dur.
module tb_pulse_receiver_capture;

  logic        clk = 1'b0;
  logic        sys_rst_n, en, invert, sig_in, rd_en, overflow_clr;
  logic [7:0]  prescale;
  logic [11:0] idle_threshold;
  logic [13:0] rd_data;
  logic        rd_valid, overflow, idle_irq;
  logic [2:0]  fifo_count;

  int n_chk = 0;
  int n_err = 0;

  pulse_receiver_capture dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .en(en), .invert(invert),
    .prescale(prescale), .idle_threshold(idle_threshold), .sig_in(sig_in),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr), .idle_irq(idle_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // advance n rising edges, land 1 time unit after the last
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0; en = 1'b0; invert = 1'b0; sig_in = 1'b1;
    rd_en = 1'b0; overflow_clr = 1'b0; prescale = 8'd0; idle_threshold = 12'd0;
    step(3);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_irq", idle_irq, 0);
    chk("rst_data", rd_data, 0);
    sys_rst_n = 1'b1;
    step(4);
    en = 1'b1;
    step(6);

    // 1: high 10 discarded, low 5, high 7
    sig_in = 1'b0; step(5);
    sig_in = 1'b1; step(2);
    chk("t1_lat_pre", rd_valid, 0);
    step(1);
    chk("t1_lat", rd_valid, 1);
    chk("t1_rec0", rd_data, 5);
    step(4);
    sig_in = 1'b0; step(2);
    chk("t1_cnt1", fifo_count, 1);
    step(1);
    chk("t1_cnt2", fifo_count, 2);
    pop1;
    chk("t1_rec1", rd_data, 4096 + 7);
    pop1;
    chk("t1_empty", rd_valid, 0);
    chk("t1_empty_data", rd_data, 0);

    // 2: prescale=3: high 5 ->1, low 18 ->4, high 3 ->0, long low saturates
    prescale = 8'd3;
    sig_in = 1'b1; step(4);
    pop1;              // drop the record for the long preceding low
    step(0);
    sig_in = 1'b0; step(18);
    sig_in = 1'b1; step(3);
    sig_in = 1'b0; step(20000);
    sig_in = 1'b1; step(4);
    chk("t2_cnt", fifo_count, 4);
    chk("t2_ovf", overflow, 0);
    chk("t2_r0", rd_data, 4096 + 1);
    pop1; chk("t2_r1", rd_data, 4);
    pop1; chk("t2_r2", rd_data, 4096);
    pop1; chk("t2_r3", rd_data, 4095);
    pop1; chk("t2_empty", fifo_count, 0);

    // 3: idle timeout at 20 on a low line
    prescale = 8'd0; idle_threshold = 12'd20;
    sig_in = 1'b0; step(3);
    pop1;              // high segment record, length not of interest
    step(18);
    chk("t3_pre_valid", rd_valid, 0);
    chk("t3_pre_irq", idle_irq, 0);
    step(1);
    chk("t3_valid", rd_valid, 1);
    chk("t3_irq", idle_irq, 1);
    chk("t3_rec", rd_data, 8192 + 20);
    step(1);
    chk("t3_irq_off", idle_irq, 0);
    chk("t3_cnt", fifo_count, 1);
    step(30);
    chk("t3_no_more", fifo_count, 1);
    chk("t3_irq_quiet", idle_irq, 0);
    pop1;
    sig_in = 1'b1; step(6);
    chk("t3_rearm_only", fifo_count, 0);
    sig_in = 1'b0; step(3);
    idle_threshold = 12'd0;
    chk("t3_after", fifo_count, 1);
    chk("t3_after_rec", rd_data, 4096 + 6);
    pop1;

    // 4: five pushes, no reads
    sig_in = 1'b1; step(3);
    pop1;              // low segment record before the burst
    step(2);
    sig_in = 1'b0; step(7);
    sig_in = 1'b1; step(8);
    sig_in = 1'b0; step(9);
    sig_in = 1'b1; step(10);
    sig_in = 1'b0; step(2);
    chk("t4_full_no_ovf", overflow, 0);
    step(1);
    chk("t4_cnt", fifo_count, 4);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", rd_data, 4096 + 6);
    sig_in = 1'b1; step(2);
    overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
    chk("t4_set_wins", overflow, 1);
    step(2);
    overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
    chk("t4_clr", overflow, 0);

    // 5: push and pop while full
    sig_in = 1'b0; step(2);
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    chk("t5_cnt", fifo_count, 4);
    chk("t5_ovf", overflow, 0);
    chk("t5_head", rd_data, 7);
    pop1; chk("t5_r1", rd_data, 4096 + 8);
    pop1; chk("t5_r2", rd_data, 9);
    pop1; chk("t5_r3", rd_data, 4096 + 6);
    pop1; chk("t5_empty", rd_valid, 0);
    pop1;
    chk("t5_pop_empty_cnt", fifo_count, 0);
    chk("t5_pop_empty_data", rd_data, 0);

    // 6: async reset mid-segment with 3 queued
    sig_in = 1'b1; step(4);
    sig_in = 1'b0; step(4);
    sig_in = 1'b1; step(4);
    chk("t6_cnt3", fifo_count, 3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_cnt", fifo_count, 0);
    chk("t6_rst_data", rd_data, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_irq", idle_irq, 0);
    step(1);
    sys_rst_n = 1'b1;
    step(5);
    chk("t6_discard", fifo_count, 0);
    sig_in = 1'b0; step(3);
    chk("t6_cnt", fifo_count, 1);
    chk("t6_rec", rd_data, 4096 + 5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
